// File: rtl/grf_wb_arbiter_pkg.sv
// Shared widths, state encoding and defaults for the GRF writeback arbiter.
package grf_wb_arbiter_pkg;
  localparam int WORD_W           = 32;
  localparam int REG_W            = 5;
  localparam int NREGS            = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } wb_state_t;
endpackage

// File: rtl/grf_wb_arbiter_scoreboard.sv
// Outstanding-write scoreboard: one pending bit per GRF register, with a
// hazard lookup that ignores the register currently being drained.
module grf_scoreboard
  import grf_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_a,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_a,
  input  logic [REG_W-1:0] look_a1,
  input  logic [REG_W-1:0] look_a2,
  input  logic [REG_W-1:0] look_a3,
  output logic [NREGS-1:0] pending,
  output logic             hit
);
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  function automatic logic is_hazard(input logic [NREGS-1:0] vec,
                                     input logic [REG_W-1:0] a,
                                     input logic             skip_en,
                                     input logic [REG_W-1:0] skip_a);
    return (a != '0) && vec[a] && !(skip_en && (a == skip_a));
  endfunction

  // Clear before set so a same-edge issue to the drained register wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_a] = 1'b0;
    if (set_en && (set_a != '0)) pend_d[set_a] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign pending = pend_q;
  assign hit     = is_hazard(pend_q, look_a1, clr_en, clr_a) ||
                   is_hazard(pend_q, look_a2, clr_en, clr_a) ||
                   is_hazard(pend_q, look_a3, clr_en, clr_a);
endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the single GRF write port between the pipeline writeback and a
// one-entry buffer of multiply/divide results, with starvation relief.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_a3,
  input  logic [WORD_W-1:0] wb_wd,
  input  logic              md_issue,
  input  logic [REG_W-1:0]  md_dst,
  input  logic              md_rvalid,
  input  logic [REG_W-1:0]  md_ra3,
  input  logic [WORD_W-1:0] md_rwd,
  output logic              md_rready,
  input  logic [REG_W-1:0]  dec_a1,
  input  logic [REG_W-1:0]  dec_a2,
  input  logic [REG_W-1:0]  dec_a3,
  output logic              grf_we,
  output logic [REG_W-1:0]  grf_a3,
  output logic [WORD_W-1:0] grf_wd,
  output logic              stall,
  output logic [NREGS-1:0]  pending
);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  wb_state_t         state_q, state_d;
  logic [AGE_W-1:0]  age_q, age_d, age_inc;
  logic [REG_W-1:0]  buf_a3_q;
  logic [WORD_W-1:0] buf_wd_q;
  logic              load;
  logic              port_free;
  logic              drain;
  logic              sb_hit;

  assign port_free = !(wb_we && (wb_a3 != '0));
  assign drain     = (state_q != ST_IDLE) && port_free;
  assign age_inc   = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);

  grf_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (md_issue),
    .set_a   (md_dst),
    .clr_en  (drain),
    .clr_a   (buf_a3_q),
    .look_a1 (dec_a1),
    .look_a2 (dec_a2),
    .look_a3 (dec_a3),
    .pending (pending),
    .hit     (sb_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      age_q    <= '0;
      buf_a3_q <= '0;
      buf_wd_q <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      if (load) begin
        buf_a3_q <= md_ra3;
        buf_wd_q <= md_rwd;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    age_d     = age_q;
    load      = 1'b0;
    md_rready = 1'b0;
    grf_we    = wb_we;
    grf_a3    = wb_a3;
    grf_wd    = wb_wd;
    stall     = sb_hit;

    // A buffered result with $0 as destination drains silently.
    if (drain) begin
      grf_we = (buf_a3_q != '0);
      grf_a3 = buf_a3_q;
      grf_wd = buf_wd_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        md_rready = 1'b1;
        if (md_rvalid) begin
          load    = 1'b1;
          age_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (port_free) begin
          state_d = ST_IDLE;
        end else begin
          age_d = age_inc;
          if (age_inc == AGE_MAX) state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        stall = 1'b1;
        if (port_free) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of buffer, starvation and scoreboard.
module tb_grf_wb_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic        md_issue;
  logic [4:0]  md_dst;
  logic        md_rvalid;
  logic [4:0]  md_ra3;
  logic [31:0] md_rwd;
  logic        md_rready;
  logic [4:0]  dec_a1, dec_a2, dec_a3;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic        stall;
  logic [31:0] pending;

  int checks = 0;
  int passes = 0;

  // Model state: is a result waiting, what it is, how long, starved yet.
  bit        m_have;
  bit [4:0]  m_a3;
  bit [31:0] m_wd;
  int        m_wait;
  bit        m_starved;
  bit [31:0] m_pend;

  grf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .md_issue(md_issue), .md_dst(md_dst),
    .md_rvalid(md_rvalid), .md_ra3(md_ra3), .md_rwd(md_rwd),
    .md_rready(md_rready),
    .dec_a1(dec_a1), .dec_a2(dec_a2), .dec_a3(dec_a3),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd),
    .stall(stall), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic idle_inputs();
    wb_we = 0; wb_a3 = 0; wb_wd = 0;
    md_issue = 0; md_dst = 0;
    md_rvalid = 0; md_ra3 = 0; md_rwd = 0;
    dec_a1 = 0; dec_a2 = 0; dec_a3 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    md_rvalid = 1; md_ra3 = 5; md_rwd = 32'h1;
    dec_a1 = 5;
    tick();
    checks++; if (md_rready !== 1'b1) $display("FAIL reset_rready: got %0b want 1", md_rready); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall); else passes++;
    checks++; if (pending !== 32'h0) $display("FAIL reset_pending: got %h want 0", pending); else passes++;
    checks++; if (grf_we !== 1'b0) $display("FAIL reset_we_idle: got %0b want 0", grf_we); else passes++;
    wb_we = 1; wb_a3 = 3; wb_wd = 32'h11;
    #1;
    checks++;
    if (grf_we !== 1'b1 || grf_a3 !== 5'd3 || grf_wd !== 32'h11)
      $display("FAIL reset_passthru: got we=%0b a3=%0d wd=%h want 1/3/00000011", grf_we, grf_a3, grf_wd);
    else passes++;
    idle_inputs();
    reset = 0;
    tick();
  endtask

  task automatic test_idle_drain();
    do_reset();
    md_issue = 1; md_dst = 5;
    tick();
    md_issue = 0;
    checks++; if (pending[5] !== 1'b1) $display("FAIL drain_pend_set: got %0b want 1", pending[5]); else passes++;
    md_rvalid = 1; md_ra3 = 5; md_rwd = 32'hDEADBEEF;
    #1;
    checks++; if (md_rready !== 1'b1) $display("FAIL drain_rready_idle: got %0b want 1", md_rready); else passes++;
    tick();
    md_rvalid = 0;
    #1;
    checks++;
    if (grf_we !== 1'b1 || grf_a3 !== 5'd5 || grf_wd !== 32'hDEADBEEF)
      $display("FAIL drain_write: got we=%0b a3=%0d wd=%h want 1/5/deadbeef", grf_we, grf_a3, grf_wd);
    else passes++;
    checks++; if (md_rready !== 1'b0) $display("FAIL drain_rready_hold: got %0b want 0", md_rready); else passes++;
    tick();
    checks++; if (pending[5] !== 1'b0) $display("FAIL drain_pend_clr: got %0b want 0", pending[5]); else passes++;
    checks++; if (grf_we !== 1'b0 || md_rready !== 1'b1) $display("FAIL drain_after: got we=%0b rready=%0b want 0/1", grf_we, md_rready); else passes++;
  endtask

  task automatic test_contention();
    do_reset();
    wb_we = 1; wb_a3 = 8; wb_wd = 32'h8888;
    md_rvalid = 1; md_ra3 = 9; md_rwd = 32'h1234;
    tick();
    md_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (grf_we !== 1'b1 || grf_a3 !== 5'd8 || grf_wd !== 32'h8888 || md_rready !== 1'b0)
        $display("FAIL contend_busy%0d: got we=%0b a3=%0d wd=%h rready=%0b want 1/8/00008888/0",
                 i, grf_we, grf_a3, grf_wd, md_rready);
      else passes++;
      tick();
    end
    wb_we = 0;
    #1;
    checks++;
    if (grf_we !== 1'b1 || grf_a3 !== 5'd9 || grf_wd !== 32'h1234 || stall !== 1'b0)
      $display("FAIL contend_drain: got we=%0b a3=%0d wd=%h stall=%0b want 1/9/00001234/0",
               grf_we, grf_a3, grf_wd, stall);
    else passes++;
    tick();
    checks++; if (md_rready !== 1'b1) $display("FAIL contend_idle: got %0b want 1", md_rready); else passes++;
  endtask

  task automatic test_starvation();
    do_reset();
    wb_we = 1; wb_a3 = 3; wb_wd = 32'h3;
    md_rvalid = 1; md_ra3 = 11; md_rwd = 32'h55;
    tick();
    md_rvalid = 0;
    checks++; if (stall !== 1'b0) $display("FAIL starve_hold0: got %0b want 0", stall); else passes++;
    for (int i = 1; i <= LIMIT; i++) begin
      tick();
      checks++;
      if (stall !== (i == LIMIT))
        $display("FAIL starve_busy%0d: got stall=%0b want %0b", i, stall, (i == LIMIT));
      else passes++;
    end
    checks++; if (grf_a3 !== 5'd3 || grf_we !== 1'b1) $display("FAIL starve_pipe_wins: got a3=%0d want 3", grf_a3); else passes++;
    wb_we = 0;
    #1;
    checks++;
    if (grf_we !== 1'b1 || grf_a3 !== 5'd11 || grf_wd !== 32'h55)
      $display("FAIL starve_drain: got we=%0b a3=%0d wd=%h want 1/11/00000055", grf_we, grf_a3, grf_wd);
    else passes++;
    tick();
    checks++; if (stall !== 1'b0) $display("FAIL starve_release: got %0b want 0", stall); else passes++;
  endtask

  task automatic test_raw();
    do_reset();
    md_issue = 1; md_dst = 7;
    tick();
    md_issue = 0;
    dec_a1 = 7;
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL raw_stall: got %0b want 1", stall); else passes++;
    wb_we = 1; wb_a3 = 2;
    md_rvalid = 1; md_ra3 = 7; md_rwd = 32'h77;
    tick();
    md_rvalid = 0;
    checks++; if (stall !== 1'b1) $display("FAIL raw_stall_hold: got %0b want 1", stall); else passes++;
    wb_we = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || grf_a3 !== 5'd7 || grf_we !== 1'b1)
      $display("FAIL raw_drain_nostall: got stall=%0b a3=%0d we=%0b want 0/7/1", stall, grf_a3, grf_we);
    else passes++;
    tick();
    checks++; if (pending[7] !== 1'b0 || stall !== 1'b0) $display("FAIL raw_after: got pend=%0b stall=%0b want 0/0", pending[7], stall); else passes++;
    dec_a1 = 0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    md_issue = 1; md_dst = 4;
    tick();
    md_issue = 0;
    wb_we = 1; wb_a3 = 1;
    md_rvalid = 1; md_ra3 = 4; md_rwd = 32'h44;
    tick();
    md_rvalid = 0;
    wb_we = 0;
    md_issue = 1; md_dst = 4;
    #1;
    checks++; if (grf_a3 !== 5'd4 || grf_we !== 1'b1) $display("FAIL simul_drain: got a3=%0d we=%0b want 4/1", grf_a3, grf_we); else passes++;
    tick();
    md_issue = 0;
    checks++; if (pending[4] !== 1'b1) $display("FAIL simul_pend: got %0b want 1", pending[4]); else passes++;
    checks++; if (md_rready !== 1'b1) $display("FAIL simul_idle: got %0b want 1", md_rready); else passes++;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    wb_we = 1; wb_a3 = 2; wb_wd = 32'h2;
    md_issue = 1; md_dst = 6;
    tick();
    md_issue = 0;
    md_rvalid = 1; md_ra3 = 6; md_rwd = 32'hAA;
    tick();
    md_rvalid = 0;
    checks++; if (md_rready !== 1'b0) $display("FAIL rst_hold_state: got %0b want 0", md_rready); else passes++;
    #2;
    reset = 1;
    #1;
    checks++; if (md_rready !== 1'b1) $display("FAIL rst_async_idle: got %0b want 1", md_rready); else passes++;
    checks++; if (pending !== 32'h0) $display("FAIL rst_async_pend: got %h want 0", pending); else passes++;
    wb_we = 0;
    #1;
    checks++; if (grf_we !== 1'b0) $display("FAIL rst_no_write: got %0b want 0", grf_we); else passes++;
    @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (grf_we !== 1'b0) $display("FAIL rst_discard%0d: got we=%0b a3=%0d want 0", i, grf_we, grf_a3); else passes++;
      tick();
    end
  endtask

  task automatic test_random();
    int       pct;
    bit       busy, draining, e_we, e_stall;
    bit [4:0] e_a3;
    bit [31:0] e_wd, n;
    bit [4:0] srcs [3];
    do_reset();
    m_have = 0; m_a3 = 0; m_wd = 0; m_wait = 0; m_starved = 0; m_pend = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case (cyc / 100)
        0: pct = 20;
        1: pct = 60;
        2: pct = 92;
        default: pct = 40;
      endcase
      wb_we     = ($urandom_range(0, 99) < pct);
      wb_a3     = 5'($urandom_range(0, 7));
      wb_wd     = $urandom;
      md_issue  = ($urandom_range(0, 99) < 30);
      md_dst    = 5'($urandom_range(0, 7));
      md_rvalid = ($urandom_range(0, 99) < 40);
      md_ra3    = 5'($urandom_range(0, 7));
      md_rwd    = $urandom;
      dec_a1    = 5'($urandom_range(0, 7));
      dec_a2    = 5'($urandom_range(0, 7));
      dec_a3    = 5'($urandom_range(0, 7));
      #2;
      busy     = wb_we && (wb_a3 != 0);
      draining = m_have && !busy;
      if (draining) begin
        e_we = (m_a3 != 0); e_a3 = m_a3; e_wd = m_wd;
      end else begin
        e_we = wb_we; e_a3 = wb_a3; e_wd = wb_wd;
      end
      srcs[0] = dec_a1; srcs[1] = dec_a2; srcs[2] = dec_a3;
      e_stall = m_starved;
      foreach (srcs[k])
        if (srcs[k] != 0 && m_pend[srcs[k]] && !(draining && srcs[k] == m_a3)) e_stall = 1;
      checks++; if (md_rready !== !m_have) $display("FAIL rnd_rready c%0d: got %0b want %0b", cyc, md_rready, !m_have); else passes++;
      checks++;
      if (grf_we !== e_we || (e_we && (grf_a3 !== e_a3 || grf_wd !== e_wd)))
        $display("FAIL rnd_grf c%0d: got we=%0b a3=%0d wd=%h want %0b/%0d/%h", cyc, grf_we, grf_a3, grf_wd, e_we, e_a3, e_wd);
      else passes++;
      checks++; if (stall !== e_stall) $display("FAIL rnd_stall c%0d: got %0b want %0b", cyc, stall, e_stall); else passes++;
      checks++; if (pending !== m_pend) $display("FAIL rnd_pend c%0d: got %h want %h", cyc, pending, m_pend); else passes++;
      @(posedge clk);
      n = m_pend;
      if (draining) n[m_a3] = 0;
      if (md_issue && md_dst != 0) n[md_dst] = 1;
      n[0] = 0;
      m_pend = n;
      if (!m_have) begin
        if (md_rvalid) begin
          m_have = 1; m_a3 = md_ra3; m_wd = md_rwd; m_wait = 0; m_starved = 0;
        end
      end else if (draining) begin
        m_have = 0; m_starved = 0;
      end else begin
        if (m_wait < LIMIT) m_wait++;
        if (m_wait >= LIMIT) m_starved = 1;
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_idle_drain();
    test_contention();
    test_starvation();
    test_raw();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
